// File: rtl/sm_seq_multiplier.sv
// sm_seq_multiplier: iterative shift-add sign/magnitude or two's-complement multiplier
module sm_seq_multiplier #(
  parameter int MAG_W = 4,
  localparam int PW = 4 * ((2 * MAG_W + 5) / 4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   operand_x,
  input  logic [MAG_W:0]   operand_y,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [PW-1:0]    product_mag
);
  localparam int CW = $clog2(MAG_W + 2);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;
  logic [PW-1:0] mcand, acc, acc_sum;
  logic [MAG_W:0] mplier, mag_x, mag_y;
  logic [CW-1:0] cnt;
  logic raw_sign, last;
  // In two's complement the most negative operand negates to 2^MAG_W, which still fits unsigned.
  assign mag_x = mode ? (operand_x[MAG_W] ? -operand_x : operand_x) : {1'b0, operand_x[MAG_W-1:0]};
  assign mag_y = mode ? (operand_y[MAG_W] ? -operand_y : operand_y) : {1'b0, operand_y[MAG_W-1:0]};
  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign last = cnt == CW'(MAG_W);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_next = state;
    if (state == IDLE && in_valid) state_next = CALC;
    else if (state == CALC && last) state_next = DONE;
    else if (state == DONE && out_ready) state_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      raw_sign <= 1'b0;
      sign <= 1'b0;
      product_mag <= '0;
    end else if (in_ready && in_valid) begin
      mcand <= PW'(mag_x);
      mplier <= mag_y;
      acc <= '0;
      cnt <= '0;
      raw_sign <= operand_x[MAG_W] ^ operand_y[MAG_W];
    end else if (state == CALC) begin
      acc <= acc_sum;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (last) begin
        product_mag <= acc_sum;
        sign <= raw_sign & |acc_sum;
      end
    end
  end
endmodule

// File: doc/sm_seq_multiplier.md
# sm_seq_multiplier

Iterative shift-add signed multiplier: the parametrised successor to our five-bit combinational sign/magnitude multiplier. It accepts two (MAG_W+1)-bit signed operands in sign-magnitude or two's-complement form. Over MAG_W+1 cycles it produces a sign bit and a zero-extended product magnitude packed as 4-bit digits for the ALU result/display path. Valid/ready handshakes on both sides let it sit between the operand register stage and the result formatter.

## Interface
- MAG_W, 4, magnitude bits per operand; operand width is MAG_W+1, legal range 2..16.
- Derived localparam PW = 4*((2*MAG_W+5)/4): product width, a whole number of digits; equals 12 for MAG_W=4.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair and mode are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- operand_x  input  MAG_W+1  multiplicand
- operand_y  input  MAG_W+1  multiplier
- mode  input  1  0 = sign-magnitude (MSB is the sign, low MAG_W bits are the magnitude); 1 = two's complement
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  downstream accepts the result
- sign  output  1  result sign; 1 = negative
- product_mag  output  PW  unsigned product magnitude; digit i is bits [4i+3:4i]

## Operation
- FSM states: IDLE, CALC, DONE. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid=1, capture operands, compute magnitudes and sign, clear the accumulator and iteration counter, then go to CALC.
- Magnitude extraction, as (MAG_W+1)-bit unsigned values:
  - mode 0: mag = operand[MAG_W-1:0], zero-extended; sign bit = operand[MAG_W].
  - mode 1: sign bit = operand[MAG_W]; mag = sign ? (~operand + 1) : operand.
  - In mode 1 the most negative operand -2^MAG_W yields mag = 2^MAG_W. This is legal, not an error.
- Raw sign = sign_x XOR sign_y.
- CALC iteration, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand magnitude to the accumulator.
  - Shift the multiplicand left by one and the multiplier right by one; increment the counter.
  - After MAG_W+1 iterations, go to DONE.
  - The accumulator is PW bits wide. The maximum product is 2^(2*MAG_W), which always fits, so no overflow is possible.
- DONE:
  - out_valid=1, with sign and product_mag driven from registers.
  - sign = raw sign AND (product != 0). A zero product is never negative; this removes sign-magnitude -0.
  - When out_ready=1, go to IDLE.
- Outputs remain stable throughout DONE regardless of input activity. Operand and mode inputs are ignored outside IDLE.
- No result is ever dropped. No new operation starts until the current result has been accepted.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, sign=0, product_mag=0, counter=0.
- Accept occurs at edge E0 (in_valid & in_ready). CALC runs at edges E1..E(MAG_W+1).
- out_valid rises after edge E(MAG_W+1): latency is MAG_W+1 cycles, or 5 for MAG_W=4.
- Result handshake at edge Ed (out_valid & out_ready): out_valid falls and in_ready rises after Ed. The next accept is possible at edge Ed+1.
- Minimum initiation interval is MAG_W+3 cycles.
- in_ready is a combinational decode of state; it does not depend on in_valid.
- product_mag and sign retain the last result after leaving DONE. They are only meaningful while out_valid=1.
- Reset asserted mid-CALC or mid-DONE: all registers return to reset values immediately (asynchronously). The partial result is discarded, and no out_valid is produced for that operation.
- out_ready may be held high permanently. DONE then lasts exactly one cycle.

## Test plan
All scenarios use MAG_W=4.
- Mode 0, x=5'b1_0011 (-3), y=5'b0_0101 (+5), out_ready=1 -> out_valid exactly 5 cycles after accept, sign=1, product_mag=12'h00F, DONE lasts one cycle.
- Mode 0, x=5'b0_1111, y=5'b1_1111 (+15 × -15) -> sign=1, product_mag=12'h0E1. Mode 0, x=5'b1_0000 (-0), y=5'b0_0111 -> sign=0, product_mag=12'h000.
- Mode 1, x=5'b10000 (-16), y=5'b10000 -> sign=0, product_mag=12'h100. Mode 1, x=-16, y=5'b01111 (+15) -> sign=1, product_mag=12'h0F0.
- Backpressure: out_ready=0 for 4 cycles after out_valid rises, while in_valid=1 with new operands -> outputs stable, in_ready=0, no capture. The first result is delivered, then the next operands are accepted one cycle after the handshake.
- Reset: assert rst_n=0 at CALC iteration 2 -> out_valid=0, in_ready=1, sign=0, product_mag=0 immediately. After release, the next operation (3 × 3) returns 12'h009 with correct latency.
- Random: 1000 random operand/mode pairs with random out_ready stalls, compared against a reference model of sign and |x|·|y| -> zero mismatches, no lost or duplicated results.
